// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with MEM/WB operand forwarding and load-use stall detection.
// Drives the ALU operands and opcode directly from the registered decode fields.
module id_exe_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_exe_cmd,
    input  logic [RA_W-1:0]   id_src1,
    input  logic [RA_W-1:0]   id_src2,
    input  logic              id_two_src,
    input  logic [RA_W-1:0]   id_dest,
    input  logic [DATA_W-1:0] id_reg1,
    input  logic [DATA_W-1:0] id_reg2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_wb_en,
    input  logic [RA_W-1:0]   mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_wb_en,
    input  logic [RA_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              freeze,
    input  logic              flush,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [3:0]        EXE_CMD,
    output logic              exe_valid,
    output logic              exe_wb_en,
    output logic              exe_mem_read,
    output logic              exe_mem_write,
    output logic [RA_W-1:0]   exe_dest,
    output logic [DATA_W-1:0] exe_store_val,
    output logic              hazard_stall
);

    logic              r_valid;
    logic [3:0]        r_cmd;
    logic [RA_W-1:0]   r_src1;
    logic [RA_W-1:0]   r_src2;
    logic [RA_W-1:0]   r_dest;
    logic [DATA_W-1:0] r_reg1;
    logic [DATA_W-1:0] r_reg2;
    logic [DATA_W-1:0] r_imm;
    logic              r_use_imm;
    logic              r_wb_en;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Handshake: hazard_stall is the ready-low back-pressure toward ID. A decode-slot
    // instruction transfers only on an edge with id_valid=1, hazard_stall=0, freeze=0, flush=0.
    assign hazard_stall = r_valid & r_mem_read & (r_dest != '0) & id_valid & ~flush &
                          ((id_src1 == r_dest) | (id_two_src & (id_src2 == r_dest)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_cmd       <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_dest      <= '0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (freeze) begin
            r_valid     <= r_valid;
        end else if (flush || hazard_stall) begin
            // Bubble: zeroed sources also guarantee no forwarding into a dead slot.
            r_valid     <= 1'b0;
            r_cmd       <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_dest      <= '0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= id_valid;
            r_cmd       <= id_exe_cmd;
            r_src1      <= id_src1;
            r_src2      <= id_src2;
            r_dest      <= id_dest;
            r_reg1      <= id_reg1;
            r_reg2      <= id_reg2;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_wb_en     <= id_valid & id_wb_en;
            r_mem_read  <= id_valid & id_mem_read;
            r_mem_write <= id_valid & id_mem_write;
        end
    end

    // MEM is the younger producer, so it wins over WB; register 0 is never forwarded.
    always_comb begin
        fwd_a = r_reg1;
        if (r_src1 != '0) begin
            if (mem_wb_en && (mem_dest == r_src1))
                fwd_a = mem_result;
            else if (wb_wb_en && (wb_dest == r_src1))
                fwd_a = wb_value;
        end
    end

    always_comb begin
        fwd_b = r_reg2;
        if (r_src2 != '0) begin
            if (mem_wb_en && (mem_dest == r_src2))
                fwd_b = mem_result;
            else if (wb_wb_en && (wb_dest == r_src2))
                fwd_b = wb_value;
        end
    end

    assign val1          = fwd_a;
    assign val2          = r_use_imm ? r_imm : fwd_b;
    assign exe_store_val = fwd_b;
    assign EXE_CMD       = r_cmd;
    assign exe_valid     = r_valid;
    assign exe_wb_en     = r_wb_en;
    assign exe_mem_read  = r_mem_read;
    assign exe_mem_write = r_mem_write;
    assign exe_dest      = r_dest;

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: vector table and random vectors through a scoreboard queue,
// then hand-written load-use, flush, freeze and reset sequences.
module tb_id_exe_stage;

    localparam int EXP_W = 32 * 3 + 4 + 4 + 5;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cmd;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic        two_src;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic        use_imm;
        logic        wb_en;
        logic        mem_read;
        logic        mem_write;
        logic        mwe;
        logic [4:0]  md;
        logic [31:0] mr;
        logic        wwe;
        logic [4:0]  wd;
        logic [31:0] wv;
        logic [31:0] e_val1;
        logic [31:0] e_val2;
        logic [31:0] e_store;
        logic [3:0]  e_cmd;
        logic        e_valid;
        logic        e_wb;
        logic        e_mr;
        logic        e_mw;
        logic [4:0]  e_dest;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_exe_cmd;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_two_src;
    logic [4:0]  id_dest;
    logic [31:0] id_reg1;
    logic [31:0] id_reg2;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic        id_wb_en;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        mem_wb_en;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        wb_wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        freeze;
    logic        flush;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [3:0]  EXE_CMD;
    logic        exe_valid;
    logic        exe_wb_en;
    logic        exe_mem_read;
    logic        exe_mem_write;
    logic [4:0]  exe_dest;
    logic [31:0] exe_store_val;
    logic        hazard_stall;

    logic [EXP_W-1:0] exp_q[$];
    int n_cmp;
    int n_err;
    vec_t vecs[23];

    id_exe_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_exe_cmd(id_exe_cmd),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .freeze(freeze), .flush(flush), .val1(val1), .val2(val2), .EXE_CMD(EXE_CMD),
        .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .exe_mem_write(exe_mem_write), .exe_dest(exe_dest), .exe_store_val(exe_store_val),
        .hazard_stall(hazard_stall)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_exe_cmd = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_dest = 0;
        id_reg1 = 0; id_reg2 = 0; id_imm = 0; id_use_imm = 0; id_wb_en = 0;
        id_mem_read = 0; id_mem_write = 0;
        mem_wb_en = 0; mem_dest = 0; mem_result = 0; wb_wb_en = 0; wb_dest = 0; wb_value = 0;
        freeze = 0; flush = 0;
    endtask

    task automatic drive_id(input vec_t v);
        id_valid = v.valid; id_exe_cmd = v.cmd; id_src1 = v.src1; id_src2 = v.src2;
        id_two_src = v.two_src; id_dest = v.dest; id_reg1 = v.reg1; id_reg2 = v.reg2;
        id_imm = v.imm; id_use_imm = v.use_imm; id_wb_en = v.wb_en;
        id_mem_read = v.mem_read; id_mem_write = v.mem_write;
    endtask

    task automatic drive_fwd(input vec_t v);
        mem_wb_en = v.mwe; mem_dest = v.md; mem_result = v.mr;
        wb_wb_en = v.wwe; wb_dest = v.wd; wb_value = v.wv;
    endtask

    // Scoreboard helpers
    function automatic logic [EXP_W-1:0] pk(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] s, input logic [3:0] c,
                                             input logic vl, input logic w, input logic r,
                                             input logic m, input logic [4:0] d);
        return {a, b, s, c, vl, w, r, m, d};
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] s, input logic [31:0] r, input vec_t v);
        if (s == 5'd0) return r;
        if (v.mwe && v.md == s) return v.mr;
        if (v.wwe && v.wd == s) return v.wv;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] exp;
        drive_id(v);
        flush = 0;
        freeze = 0;
        exp_q.push_back(pk(v.e_val1, v.e_val2, v.e_store, v.e_cmd, v.e_valid, v.e_wb,
                           v.e_mr, v.e_mw, v.e_dest));
        tick();
        drive_fwd(v);
        id_valid = 0;
        #1;
        act = pk(val1, val2, exe_store_val, EXE_CMD, exe_valid, exe_wb_en, exe_mem_read,
                 exe_mem_write, exe_dest);
        exp = exp_q.pop_front();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d: got %h expected %h", i, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        rst_n = 1;

        // Reset with a register-0 forward pending on both paths
        #1 rst_n = 0;
        id_valid = 1; id_dest = 3; id_mem_read = 1; id_reg1 = 32'h55;
        mem_wb_en = 1; mem_dest = 0; mem_result = 32'hDEADBEEF;
        wb_wb_en = 1; wb_dest = 0; wb_value = 32'h12345678;
        tick();
        tick();
        check("rst_val1", val1, 0);
        check("rst_val2", val2, 0);
        check("rst_cmd", 32'(EXE_CMD), 0);
        check("rst_valid", 32'(exe_valid), 0);
        check("rst_wb_en", 32'(exe_wb_en), 0);
        check("rst_mem_rd", 32'(exe_mem_read), 0);
        check("rst_mem_wr", 32'(exe_mem_write), 0);
        check("rst_dest", 32'(exe_dest), 0);
        check("rst_store", exe_store_val, 0);
        check("rst_stall", 32'(hazard_stall), 0);
        clear_inputs();
        rst_n = 1;
        tick();

        // Fixed vectors
        for (int i = 0; i < 23; i++) vecs[i] = '0;
        // basic capture
        vecs[0].valid = 1; vecs[0].src1 = 1; vecs[0].src2 = 2; vecs[0].two_src = 1;
        vecs[0].dest = 3; vecs[0].reg1 = 5; vecs[0].reg2 = 7; vecs[0].wb_en = 1;
        vecs[0].e_val1 = 5; vecs[0].e_val2 = 7; vecs[0].e_store = 7; vecs[0].e_valid = 1;
        vecs[0].e_wb = 1; vecs[0].e_dest = 3;
        // MEM beats WB
        vecs[1].valid = 1; vecs[1].cmd = 2; vecs[1].src1 = 3; vecs[1].dest = 4;
        vecs[1].reg1 = 1; vecs[1].reg2 = 2; vecs[1].mwe = 1; vecs[1].md = 3; vecs[1].mr = 32'h11;
        vecs[1].wwe = 1; vecs[1].wd = 3; vecs[1].wv = 32'h22;
        vecs[1].e_val1 = 32'h11; vecs[1].e_val2 = 2; vecs[1].e_store = 2; vecs[1].e_cmd = 2;
        vecs[1].e_valid = 1; vecs[1].e_dest = 4;
        // WB when MEM is off
        vecs[2] = vecs[1]; vecs[2].mwe = 0; vecs[2].e_val1 = 32'h22;
        // immediate with forwarded store data
        vecs[3].valid = 1; vecs[3].cmd = 5; vecs[3].src2 = 4; vecs[3].two_src = 1;
        vecs[3].reg1 = 32'h40; vecs[3].reg2 = 3; vecs[3].use_imm = 1; vecs[3].imm = 32'hFFFFFFFC;
        vecs[3].mem_write = 1; vecs[3].wwe = 1; vecs[3].wd = 4; vecs[3].wv = 32'h99;
        vecs[3].e_val1 = 32'h40; vecs[3].e_val2 = 32'hFFFFFFFC; vecs[3].e_store = 32'h99;
        vecs[3].e_cmd = 5; vecs[3].e_valid = 1; vecs[3].e_mw = 1;
        // register 0 never forwarded
        vecs[4].valid = 1; vecs[4].cmd = 1; vecs[4].reg1 = 32'h123; vecs[4].reg2 = 32'h456;
        vecs[4].mwe = 1; vecs[4].mr = 32'hDEAD; vecs[4].wwe = 1; vecs[4].wv = 32'hBEEF;
        vecs[4].e_val1 = 32'h123; vecs[4].e_val2 = 32'h456; vecs[4].e_store = 32'h456;
        vecs[4].e_cmd = 1; vecs[4].e_valid = 1;
        // invalid slot masks control bits
        vecs[5].cmd = 7; vecs[5].src1 = 5; vecs[5].reg1 = 8; vecs[5].dest = 9;
        vecs[5].wb_en = 1; vecs[5].mem_read = 1; vecs[5].mem_write = 1;
        vecs[5].e_val1 = 8; vecs[5].e_cmd = 7; vecs[5].e_dest = 9;
        // independent paths per operand
        vecs[6].valid = 1; vecs[6].cmd = 9; vecs[6].src1 = 7; vecs[6].src2 = 8; vecs[6].dest = 10;
        vecs[6].reg1 = 1; vecs[6].reg2 = 2; vecs[6].mwe = 1; vecs[6].md = 8; vecs[6].mr = 32'hAA;
        vecs[6].wwe = 1; vecs[6].wd = 7; vecs[6].wv = 32'hBB;
        vecs[6].e_val1 = 32'hBB; vecs[6].e_val2 = 32'hAA; vecs[6].e_store = 32'hAA;
        vecs[6].e_cmd = 9; vecs[6].e_valid = 1; vecs[6].e_dest = 10;

        // Random vectors (no loads, so no stall between them)
        for (int i = 7; i < 23; i++) begin
            v = '0;
            v.valid = 1'($urandom_range(0, 1)); v.cmd = 4'($urandom_range(0, 15));
            v.src1 = 5'($urandom_range(0, 3)); v.src2 = 5'($urandom_range(0, 3));
            v.dest = 5'($urandom_range(0, 31)); v.reg1 = $urandom; v.reg2 = $urandom;
            v.imm = $urandom; v.use_imm = 1'($urandom_range(0, 1));
            v.wb_en = 1'($urandom_range(0, 1)); v.mem_write = 1'($urandom_range(0, 1));
            v.mwe = 1'($urandom_range(0, 1)); v.md = 5'($urandom_range(0, 3)); v.mr = $urandom;
            v.wwe = 1'($urandom_range(0, 1)); v.wd = 5'($urandom_range(0, 3)); v.wv = $urandom;
            v.e_val1 = model_fwd(v.src1, v.reg1, v);
            v.e_store = model_fwd(v.src2, v.reg2, v);
            v.e_val2 = v.use_imm ? v.imm : v.e_store;
            v.e_cmd = v.cmd; v.e_valid = v.valid; v.e_wb = v.valid & v.wb_en;
            v.e_mw = v.valid & v.mem_write; v.e_dest = v.dest;
            vecs[i] = v;
        end
        for (int i = 0; i < 23; i++) run_vec(i, vecs[i]);
        clear_inputs();
        tick();

        // Load-use: one bubble, then consumer enters with WB-forwarded load data
        id_valid = 1; id_mem_read = 1; id_wb_en = 1; id_dest = 6; id_src1 = 1; id_src2 = 2;
        tick();
        clear_inputs();
        id_valid = 1; id_src1 = 6; id_reg1 = 32'h5; id_dest = 7; id_wb_en = 1; id_exe_cmd = 3;
        #1;
        check("lu_stall", 32'(hazard_stall), 1);
        tick();
        check("lu_bubble_valid", 32'(exe_valid), 0);
        check("lu_bubble_wb", 32'(exe_wb_en), 0);
        check("lu_bubble_stall", 32'(hazard_stall), 0);
        tick();
        wb_wb_en = 1; wb_dest = 6; wb_value = 32'h77;
        #1;
        check("lu_enter_valid", 32'(exe_valid), 1);
        check("lu_enter_dest", 32'(exe_dest), 7);
        check("lu_enter_cmd", 32'(EXE_CMD), 3);
        check("lu_enter_val1", val1, 32'h77);
        clear_inputs();

        // src2 matching depends on two_src; flush suppresses the stall
        id_valid = 1; id_mem_read = 1; id_wb_en = 1; id_dest = 6;
        tick();
        clear_inputs();
        id_valid = 1; id_src1 = 1; id_src2 = 6; id_two_src = 0; id_dest = 8;
        #1;
        check("two_src_off", 32'(hazard_stall), 0);
        id_two_src = 1;
        #1;
        check("two_src_on", 32'(hazard_stall), 1);
        flush = 1;
        #1;
        check("flush_kills_stall", 32'(hazard_stall), 0);
        tick();
        check("flush_bubble_valid", 32'(exe_valid), 0);
        check("flush_bubble_rd", 32'(exe_mem_read), 0);
        clear_inputs();
        id_valid = 1; id_dest = 9; id_exe_cmd = 4; id_reg1 = 32'h31; id_wb_en = 1;
        #1;
        check("after_flush_stall", 32'(hazard_stall), 0);
        tick();
        check("one_bubble_valid", 32'(exe_valid), 1);
        check("one_bubble_dest", 32'(exe_dest), 9);

        // Freeze holds for 3 cycles, ignoring an overlapping flush
        freeze = 1;
        id_dest = 12; id_exe_cmd = 15; id_reg1 = 32'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 1) flush = 1;
            check("frz_dest", 32'(exe_dest), 9);
            check("frz_cmd", 32'(EXE_CMD), 4);
            check("frz_val1", val1, 32'h31);
            check("frz_valid", 32'(exe_valid), 1);
        end
        freeze = 0;
        tick();
        check("frz_flush_bubble", 32'(exe_valid), 0);
        flush = 0;

        // Reset asserted mid-freeze clears immediately; first edge after release captures
        tick();
        check("pre_rst_dest", 32'(exe_dest), 12);
        freeze = 1;
        #2 rst_n = 0;
        #1;
        check("rst_frz_valid", 32'(exe_valid), 0);
        check("rst_frz_dest", 32'(exe_dest), 0);
        check("rst_frz_cmd", 32'(EXE_CMD), 0);
        tick();
        rst_n = 1; freeze = 0; id_dest = 5; id_exe_cmd = 2; id_valid = 1;
        tick();
        check("post_rst_valid", 32'(exe_valid), 1);
        check("post_rst_dest", 32'(exe_dest), 5);
        check("post_rst_cmd", 32'(EXE_CMD), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
